// File: rtl/perceptron_trainer_if.sv
// Sample/result handshake bundle between a sample source and perceptron_trainer.
// The source side uses the master modport, the trainer the slave modport.
interface perceptron_trainer_if #(
  parameter int N_INPUTS = 16
);
  logic                sample_valid;
  logic                sample_ready;
  logic [N_INPUTS-1:0] sample_x;
  logic                sample_label;
  logic                train_en;
  logic                result_valid;
  logic                result_pred;
  logic                result_miss;

  modport master (
    output sample_valid, sample_x, sample_label, train_en,
    input  sample_ready, result_valid, result_pred, result_miss
  );

  modport slave (
    input  sample_valid, sample_x, sample_label, train_en,
    output sample_ready, result_valid, result_pred, result_miss
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Sequential perceptron trainer: evaluates one weight per cycle, then applies the
// saturating perceptron rule on a trained mispredict. Optional: PERCEPTRON_ERRCNT_EN.
module perceptron_trainer #(
  parameter int N_INPUTS = 16,
  parameter int WEIGHT_W = 8,
  parameter int LR       = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  perceptron_trainer_if.slave               smp,
  output logic                              busy,
  input  logic [$clog2(N_INPUTS)-1:0]       rd_idx,
  output logic signed [WEIGHT_W-1:0]        rd_weight,
  output logic signed [WEIGHT_W-1:0]        bias,
  output logic [15:0]                       err_count,
  input  logic                              err_clr
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int ACC_W = WEIGHT_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_EVAL = CNT_W'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0] LAST_UPD  = CNT_W'(N_INPUTS);
  localparam logic signed [WEIGHT_W:0] STEP  = (WEIGHT_W+1)'(LR);
  localparam logic signed [WEIGHT_W:0] W_MAX = (WEIGHT_W+1)'((1 << (WEIGHT_W - 1)) - 1);
  localparam logic signed [WEIGHT_W:0] W_MIN = -W_MAX - (WEIGHT_W+1)'(1);

  typedef enum logic [1:0] {IDLE, EVAL, DECIDE, UPDATE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           idx;
  logic [IDX_W-1:0]           sel;
  logic [N_INPUTS-1:0]        x_q;
  logic                       label_q;
  logic                       train_q;
  logic signed [ACC_W-1:0]    acc, acc_nxt;
  logic signed [WEIGHT_W-1:0] w [N_INPUTS];
  logic                       accept;

  // One learning step toward the label, clamped to the signed weight range.
  function automatic logic signed [WEIGHT_W-1:0] sat_step(
    input logic signed [WEIGHT_W-1:0] v,
    input logic                       up
  );
    logic signed [WEIGHT_W:0] s;
    s = up ? {v[WEIGHT_W-1], v} + STEP : {v[WEIGHT_W-1], v} - STEP;
    if (s > W_MAX)      return W_MAX[WEIGHT_W-1:0];
    else if (s < W_MIN) return W_MIN[WEIGHT_W-1:0];
    else                return s[WEIGHT_W-1:0];
  endfunction

  assign sel    = idx[IDX_W-1:0];
  assign accept = smp.sample_valid && smp.sample_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    acc_nxt = acc;
    if (x_q[sel]) acc_nxt = acc + ACC_W'(w[sel]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EVAL;
      EVAL:    if (idx == LAST_EVAL) state_nxt = DECIDE;
      DECIDE:  state_nxt = (smp.result_miss && train_q) ? UPDATE : IDLE;
      UPDATE:  if (idx == LAST_UPD) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    smp.sample_ready = (state == IDLE);
    smp.result_valid = (state == DECIDE);
    busy             = (state != IDLE);
  end

  // Prediction is registered on the last EVAL edge so it is stable while result_valid is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx             <= '0;
      x_q             <= '0;
      label_q         <= 1'b0;
      train_q         <= 1'b0;
      acc             <= '0;
      bias            <= '0;
      rd_weight       <= '0;
      smp.result_pred <= 1'b0;
      smp.result_miss <= 1'b0;
      // NOTE: the weight array is reset explicitly; a reset must discard all training.
      for (int i = 0; i < N_INPUTS; i++) w[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so a same-cycle update reads back stale.
      rd_weight <= (int'(rd_idx) < N_INPUTS) ? w[rd_idx] : '0;
      case (state)
        IDLE: if (accept) begin
          x_q     <= smp.sample_x;
          label_q <= smp.sample_label;
          train_q <= smp.train_en;
          acc     <= ACC_W'(bias);
          idx     <= '0;
        end
        EVAL: begin
          acc <= acc_nxt;
          idx <= idx + CNT_W'(1);
          if (idx == LAST_EVAL) begin
            smp.result_pred <= ~acc_nxt[ACC_W-1];
            smp.result_miss <= ~acc_nxt[ACC_W-1] ^ label_q;
          end
        end
        DECIDE: idx <= '0;
        UPDATE: begin
          idx <= idx + CNT_W'(1);
          if (idx == LAST_UPD)  bias   <= sat_step(bias, label_q);
          else if (x_q[sel])    w[sel] <= sat_step(w[sel], label_q);
        end
        default: idx <= '0;
      endcase
    end
  end

`ifdef PERCEPTRON_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (state == DECIDE && smp.result_miss && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: a default-LR instance plus a large-LR
// instance that reaches saturation quickly; expectations come from an arithmetic model.
module tb_perceptron_trainer;
  localparam int N      = 16;
  localparam int WW     = 8;
  localparam int LR_SAT = 100;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  perceptron_trainer_if #(.N_INPUTS(N)) bus0 ();
  perceptron_trainer_if #(.N_INPUTS(N)) bus1 ();

  logic              busy0, busy1;
  logic [3:0]        rd_idx0, rd_idx1;
  logic signed [7:0] rd_w0, rd_w1, bias0, bias1;
  logic [15:0]       errc0, errc1;
  logic              err_clr0, err_clr1;

  perceptron_trainer #(.N_INPUTS(N), .WEIGHT_W(WW), .LR(1)) dut (
    .clk(clk), .rst_n(rst_n), .smp(bus0.slave), .busy(busy0), .rd_idx(rd_idx0),
    .rd_weight(rd_w0), .bias(bias0), .err_count(errc0), .err_clr(err_clr0));

  perceptron_trainer #(.N_INPUTS(N), .WEIGHT_W(WW), .LR(LR_SAT)) dut_sat (
    .clk(clk), .rst_n(rst_n), .smp(bus1.slave), .busy(busy1), .rd_idx(rd_idx1),
    .rd_weight(rd_w1), .bias(bias1), .err_count(errc1), .err_clr(err_clr1));

  typedef struct packed {
    logic pred;
    logic miss;
    int   cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   mw [2][N];
  int   mb [2];
  int   merr [2];
  int   lr [2] = '{1, LR_SAT};
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic int clamp(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < N; i++) mw[u][i] = 0;
      mb[u]   = 0;
      merr[u] = 0;
    end
  endfunction

  // Perceptron rule: predict on sign of bias + sum of active weights, step on a trained miss.
  function automatic void model_apply(input int u, input logic [15:0] x, input int label,
                                      input int te, output int pred, output int miss);
    int acc = mb[u];
    int dir;
    for (int i = 0; i < N; i++) if (x[i]) acc += mw[u][i];
    pred = (acc >= 0) ? 1 : 0;
    miss = (pred != label) ? 1 : 0;
    if (miss == 1 && merr[u] < 65535) merr[u]++;
    if (miss == 1 && te == 1) begin
      dir = (label == 1) ? lr[u] : -lr[u];
      for (int i = 0; i < N; i++) if (x[i]) mw[u][i] = clamp(mw[u][i] + dir);
      mb[u] = clamp(mb[u] + dir);
    end
  endfunction

  function automatic logic get_ready(input int u);
    return (u == 0) ? bus0.sample_ready : bus1.sample_ready;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  task automatic drive(input int u, input logic v, input logic [15:0] x, input logic l, input logic t);
    if (u == 0) begin
      bus0.sample_valid = v; bus0.sample_x = x; bus0.sample_label = l; bus0.train_en = t;
    end else begin
      bus1.sample_valid = v; bus1.sample_x = x; bus1.sample_label = l; bus1.train_en = t;
    end
  endtask

  task automatic send(input int u, input logic [15:0] x, input logic lbl, input logic te,
                      input bit wait_idle, output int acc_cyc);
    int   guard = 0;
    int   pred, miss, exp_busy, nbusy;
    exp_t e;
    @(negedge clk);
    drive(u, 1'b1, x, lbl, te);
    while (!get_ready(u) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    acc_cyc = cyc;
    if (guard >= 200) begin
      fail_now("accept_wait");
      drive(u, 1'b0, 16'h0, 1'b0, 1'b0);
      return;
    end
    @(posedge clk);
    model_apply(u, x, int'(lbl), int'(te), pred, miss);
    e.pred = pred[0];
    e.miss = miss[0];
    e.cyc  = acc_cyc;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    exp_busy = (miss == 1 && te) ? 2 * (N + 1) : N + 1;
    @(negedge clk);
    drive(u, 1'b0, 16'($urandom), 1'($urandom), 1'($urandom));
    if (wait_idle) begin
      nbusy = 0;
      while (get_busy(u) && nbusy < 100) begin
        nbusy++;
        @(negedge clk);
      end
      check($sformatf("busy_len%0d", u), nbusy, exp_busy);
    end
  endtask

  task automatic check_rd(input int u, input int idx, input int expected, input string name);
    @(negedge clk);
    if (u == 0) rd_idx0 = 4'(idx);
    else        rd_idx1 = 4'(idx);
    @(negedge clk);
    check(name, (u == 0) ? int'(rd_w0) : int'(rd_w1), expected);
  endtask

  task automatic check_weights(input int u, input string tag);
    for (int i = 0; i < N; i++) check_rd(u, i, mw[u][i], $sformatf("%s_w%0d", tag, i));
    check($sformatf("%s_bias", tag), (u == 0) ? int'(bias0) : int'(bias1), mb[u]);
  endtask

  task automatic check_err0(input string name);
`ifdef PERCEPTRON_ERRCNT_EN
    check(name, int'(errc0), merr[0]);
`else
    check(name, int'(errc0), 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus0.result_valid) begin
        if (q0.size() == 0) fail_now("unexpected_result0");
        else begin
          e = q0.pop_front();
          check("pred0", int'(bus0.result_pred), int'(e.pred));
          check("miss0", int'(bus0.result_miss), int'(e.miss));
          check("latency0", cyc - e.cyc, N + 1);
        end
      end
      if (bus1.result_valid) begin
        if (q1.size() == 0) fail_now("unexpected_result1");
        else begin
          e = q1.pop_front();
          check("pred1", int'(bus1.result_pred), int'(e.pred));
          check("miss1", int'(bus1.result_miss), int'(e.miss));
          check("latency1", cyc - e.cyc, N + 1);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    int guard;
    rst_n    = 1'b0;
    rd_idx0  = '0;
    rd_idx1  = '0;
    err_clr0 = 1'b0;
    err_clr1 = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0, 1'b0);
    model_reset();
    do_reset();

    @(negedge clk);
    check("rst_ready", int'(bus0.sample_ready), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_valid", int'(bus0.result_valid), 0);
    check("rst_pred", int'(bus0.result_pred), 0);
    check("rst_miss", int'(bus0.result_miss), 0);
    check_err0("rst_errcnt");
    check_weights(0, "rst");

    // First trained mispredict, then the same sample predicts correctly.
    send(0, 16'h0001, 1'b0, 1'b1, 1'b1, a);
    check_rd(0, 0, -1, "t1_w0_const");
    check("t1_bias_const", int'(bias0), -1);
    check_weights(0, "t1");
    send(0, 16'h0001, 1'b0, 1'b1, 1'b1, a);
    check_weights(0, "t2");

    // Mispredict with training disabled leaves the model untouched.
    send(0, 16'h0000, 1'b1, 1'b0, 1'b1, a);
    check("noupd_miss_held", int'(bus0.result_miss), 1);
    check_err0("noupd_errcnt");
    check_weights(0, "noupd");
    @(negedge clk);
    err_clr0 = 1'b1;
    @(negedge clk);
    err_clr0 = 1'b0;
    merr[0]  = 0;
    check_err0("errclr");

    for (int k = 0; k < 40; k++)
      send(0, 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, a);
    check_weights(0, "rand0");
    check_err0("rand_errcnt");

    do_reset();
    for (int k = 0; k < 130; k++) send(0, 16'h8000, 1'b1, 1'b1, 1'b1, a);
    check_weights(0, "rep8000");

    // Reset asserted in UPDATE cycle 5 aborts the sample and clears training.
    send(0, 16'h0001, 1'b0, 1'b1, 1'b0, a);
    guard = 0;
    while (cyc < a + 2 * (N + 1) - 11 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("abort_busy_before", int'(busy0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("abort_busy", int'(busy0), 0);
    check("abort_ready", int'(bus0.sample_ready), 1);
    check("abort_bias", int'(bias0), 0);
    check("abort_valid", int'(bus0.result_valid), 0);
    check_weights(0, "abort");

    // Large-step instance: drive w15 into both saturation limits.
    send(1, 16'h0001, 1'b0, 1'b1, 1'b1, a);
    send(1, 16'h8001, 1'b1, 1'b1, 1'b1, a);
    send(1, 16'h0001, 1'b0, 1'b1, 1'b1, a);
    send(1, 16'h8001, 1'b1, 1'b1, 1'b1, a);
    check_rd(1, 15, 127, "sat_pos_w15");
    send(1, 16'h8000, 1'b0, 1'b1, 1'b1, a);
    send(1, 16'h0001, 1'b1, 1'b1, 1'b1, a);
    send(1, 16'h8001, 1'b0, 1'b1, 1'b1, a);
    send(1, 16'h0001, 1'b1, 1'b1, 1'b1, a);
    send(1, 16'h8001, 1'b0, 1'b1, 1'b1, a);
    check_rd(1, 15, -128, "sat_neg_w15");
    check_weights(1, "sat_dir");
    for (int k = 0; k < 40; k++)
      send(1, 16'($urandom), 1'($urandom), 1'b1, 1'b1, a);
    check_weights(1, "sat_rand");

    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
